pool_window_buffer: RTL and testbench

Parametrised ping-pong row buffer between the C1 convolution PE array and the 2x2 max-pooling unit. It accepts one pixel per cycle for all channels in raster order and stores two rows per bank in two banks. It then emits non-overlapping 2x2 windows for every channel, with valid/ready backpressure on both sides and a frame-end indication. It generalises the fixed 6-channel, 28-column, 8-bit C1 register stage so the same block can serve C1 and later layers.

---
 rtl/pool_window_buffer.sv | 167 ++++++++++++++++
 tb/tb_pool_window_buffer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_buffer.sv
// Ping-pong row buffer feeding the 2x2 max-pooling unit: two banks of two rows,
// filled in raster order and drained as non-overlapping 2x2 windows for every channel.
module pool_window_buffer #(
   parameter int DW   = 8,
   parameter int CH   = 6,
   parameter int COLS = 28,
   parameter int ROWS = 28,
   localparam int WC_W = (COLS > 2) ? $clog2(COLS / 2) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CH*DW-1:0]     in_data,
   output logic                 win_valid,
   input  logic                 win_ready,
   output logic [CH*4*DW-1:0]   win_data,
   output logic                 frame_done,
   output logic [WC_W-1:0]      win_col
);

   localparam int PIX_W = CH * DW;
   localparam int WIN_W = 4 * DW;
   localparam int COL_W = $clog2(COLS);
   localparam int BC_W  = (ROWS > 2) ? $clog2(ROWS / 2) : 1;
   localparam logic [COL_W-1:0] LAST_WR_COL = COL_W'(COLS - 1);
   localparam logic [WC_W-1:0]  LAST_RD_COL = WC_W'(COLS / 2 - 1);
   localparam logic [BC_W-1:0]  LAST_BANK   = BC_W'(ROWS / 2 - 1);

   // Row storage addressed by {bank, row}; contents are never reset.
   logic [PIX_W-1:0]     mem [4][COLS];

   logic                 wr_bank;
   logic                 wr_row;
   logic [COL_W-1:0]     wr_col;
   logic                 rd_bank;
   logic [WC_W-1:0]      rd_col;
   logic [BC_W-1:0]      bank_cnt;
   logic [1:0]           bank_full;

   logic                 wr_fire;
   logic                 wr_wrap;
   logic                 bank_set;
   logic                 load;
   logic                 rd_wrap;
   logic                 bank_clr;
   logic [COL_W-1:0]     rd_c0;
   logic [COL_W-1:0]     rd_c1;
   logic [PIX_W-1:0]     r0a;
   logic [PIX_W-1:0]     r0b;
   logic [PIX_W-1:0]     r1a;
   logic [PIX_W-1:0]     r1b;
   logic [CH*WIN_W-1:0]  win_nxt;

   logic [CH*WIN_W-1:0]  win_data_p1;
   logic [WC_W-1:0]      win_col_p1;
   logic                 last_p1;
   logic                 vld_p1;

   function automatic logic [CH*WIN_W-1:0] pack_window(
      input logic [PIX_W-1:0] a,
      input logic [PIX_W-1:0] b,
      input logic [PIX_W-1:0] c,
      input logic [PIX_W-1:0] d
   );
      logic [CH*WIN_W-1:0] w;
      w = '0;
      for (int k = 0; k < CH; k++) begin
         w[k*WIN_W +: WIN_W] = {a[k*DW +: DW], b[k*DW +: DW], c[k*DW +: DW], d[k*DW +: DW]};
      end
      return w;
   endfunction

   assign in_ready = rst_n && !bank_full[wr_bank];
   assign wr_fire  = in_valid && in_ready;
   assign wr_wrap  = (wr_col == LAST_WR_COL);
   assign bank_set = wr_fire && wr_wrap && wr_row;

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[{wr_bank, wr_row}][wr_col] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_bank <= 1'b0;
         wr_row  <= 1'b0;
         wr_col  <= '0;
      end else if (wr_fire) begin
         if (wr_wrap) begin
            wr_col <= '0;
            wr_row <= ~wr_row;
            if (wr_row) begin
               wr_bank <= ~wr_bank;
            end
         end else begin
            wr_col <= wr_col + COL_W'(1);
         end
      end
   end

   // Writer fills only a non-full bank and the reader drains only a full one,
   // so set and clear always land on different banks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank_full <= 2'b00;
      end else begin
         if (bank_set) begin
            bank_full[wr_bank] <= 1'b1;
         end
         if (bank_clr) begin
            bank_full[rd_bank] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(bank_set && bank_clr && (wr_bank == rd_bank)));
      end
   end

   assign load     = bank_full[rd_bank] && (!vld_p1 || win_ready);
   assign rd_wrap  = (rd_col == LAST_RD_COL);
   assign bank_clr = load && rd_wrap;
   assign rd_c0    = COL_W'({rd_col, 1'b0});
   assign rd_c1    = COL_W'({rd_col, 1'b1});
   assign r0a      = mem[{rd_bank, 1'b0}][rd_c0];
   assign r0b      = mem[{rd_bank, 1'b0}][rd_c1];
   assign r1a      = mem[{rd_bank, 1'b1}][rd_c0];
   assign r1b      = mem[{rd_bank, 1'b1}][rd_c1];
   assign win_nxt  = pack_window(r0a, r0b, r1a, r1b);

   // Stage p1: output window register, loaded whenever it is empty or being consumed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_bank     <= 1'b0;
         rd_col      <= '0;
         bank_cnt    <= '0;
         vld_p1      <= 1'b0;
         win_data_p1 <= '0;
         win_col_p1  <= '0;
         last_p1     <= 1'b0;
      end else if (load) begin
         vld_p1      <= 1'b1;
         win_data_p1 <= win_nxt;
         win_col_p1  <= rd_col;
         last_p1     <= rd_wrap && (bank_cnt == LAST_BANK);
         if (rd_wrap) begin
            rd_col   <= '0;
            rd_bank  <= ~rd_bank;
            bank_cnt <= (bank_cnt == LAST_BANK) ? '0 : bank_cnt + BC_W'(1);
         end else begin
            rd_col   <= rd_col + WC_W'(1);
         end
      end else if (vld_p1 && win_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign win_valid  = vld_p1;
   assign win_data   = win_data_p1;
   assign win_col    = win_col_p1;
   assign frame_done = vld_p1 && win_ready && last_p1;

endmodule

// File: tb/tb_pool_window_buffer.sv
// Bench for pool_window_buffer: queue-based window model for the 28x28x6 build,
// plus a directed ramp check of a 16-bit, 16-channel, 4x2 build.
module tb_pool_window_buffer;

   localparam int DW    = 8;
   localparam int CH    = 6;
   localparam int COLS  = 28;
   localparam int ROWS  = 28;
   localparam int PW    = CH * DW;
   localparam int WW    = CH * 4 * DW;
   localparam int FRAME = COLS * ROWS;
   localparam int BANK  = 2 * COLS;

   localparam int SDW   = 16;
   localparam int SCH   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [PW-1:0]   in_data;
   logic            win_valid;
   logic            win_ready;
   logic [WW-1:0]   win_data;
   logic            frame_done;
   logic [3:0]      win_col;

   logic                 rst_n_s;
   logic                 in_valid_s;
   logic                 in_ready_s;
   logic [SCH*SDW-1:0]   in_data_s;
   logic                 win_valid_s;
   logic                 win_ready_s;
   logic [SCH*4*SDW-1:0] win_data_s;
   logic                 frame_done_s;
   logic [0:0]           win_col_s;

   pool_window_buffer #(.DW(DW), .CH(CH), .COLS(COLS), .ROWS(ROWS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
      .frame_done(frame_done), .win_col(win_col)
   );

   pool_window_buffer #(.DW(SDW), .CH(SCH), .COLS(4), .ROWS(2)) dut_s (
      .clk(clk), .rst_n(rst_n_s), .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
      .win_valid(win_valid_s), .win_ready(win_ready_s), .win_data(win_data_s),
      .frame_done(frame_done_s), .win_col(win_col_s)
   );

   typedef struct {
      logic [WW-1:0] data;
      int            col;
      bit            last;
   } win_t;

   logic [PW-1:0] acc_q[$];
   win_t          exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  pix_idx = 0;
   int  bank_no = 0;
   int  nwin = 0;
   int  nfd = 0;
   bit  mode = 1'b0;
   bit  chk_rdy = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] pattern_pix(input int idx);
      int p;
      int r;
      int c;
      logic [PW-1:0] v;
      p = idx % FRAME;
      r = p / COLS;
      c = p % COLS;
      for (int k = 0; k < CH; k++) v[k*DW +: DW] = 8'((r * COLS + c + k) & 255);
      return v;
   endfunction

   function automatic logic [PW-1:0] rand_pix();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[PW-1:0];
   endfunction

   // A completed bank of 2*COLS pixels yields COLS/2 windows in column order.
   task automatic model_push(input logic [PW-1:0] d);
      win_t w;
      logic [PW-1:0] a, b, c, e;
      acc_q.push_back(d);
      pix_idx++;
      if (acc_q.size() == BANK) begin
         for (int x = 0; x < COLS / 2; x++) begin
            a = acc_q[2*x];
            b = acc_q[2*x+1];
            c = acc_q[COLS+2*x];
            e = acc_q[COLS+2*x+1];
            w.data = '0;
            for (int k = 0; k < CH; k++)
               w.data[k*4*DW +: 4*DW] = {a[k*DW +: DW], b[k*DW +: DW], c[k*DW +: DW], e[k*DW +: DW]};
            w.col  = x;
            w.last = (bank_no == ROWS / 2 - 1) && (x == COLS / 2 - 1);
            exp_q.push_back(w);
         end
         bank_no = (bank_no + 1) % (ROWS / 2);
         acc_q.delete();
      end
   endtask

   task automatic model_pop();
      win_t e;
      nwin++;
      if (frame_done) nfd++;
      if (exp_q.size() == 0) begin
         check("win_unexpected", 64'd1, 64'd0);
         return;
      end
      e = exp_q.pop_front();
      for (int k = 0; k < CH; k++) check("win_ch", 64'(win_data[k*4*DW +: 4*DW]), 64'(e.data[k*4*DW +: 4*DW]));
      check("win_col", 64'(win_col), 64'(e.col));
      check("frame_done", 64'(frame_done), 64'(e.last));
   endtask

   task automatic model_reset();
      acc_q.delete();
      exp_q.delete();
      bank_no = 0;
      pix_idx = 0;
      nwin = 0;
      nfd = 0;
   endtask

   task automatic cycle(input bit iv, input bit wr);
      logic [PW-1:0] d;
      d = mode ? rand_pix() : pattern_pix(pix_idx);
      in_valid  = iv;
      in_data   = d;
      win_ready = wr;
      #1;
      if (chk_rdy) check("in_ready_stream", 64'(in_ready), 64'd1);
      if (win_valid && win_ready) model_pop();
      else check("frame_done_idle", 64'(frame_done), 64'd0);
      if (in_valid && in_ready) model_push(d);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && exp_q.size() > 0; n++) cycle(1'b0, 1'b1);
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      win_ready = 1'b1;
      in_data   = '1;
      #1;
      check("in_ready_in_reset", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("rst_win_valid", 64'(win_valid), 64'd0);
      check("rst_win_col", 64'(win_col), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      for (int j = 0; j < 3; j++) check("rst_win_data", win_data[j*64 +: 64], 64'd0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("in_ready_release", 64'(in_ready), 64'd1);
      model_reset();
   endtask

   function automatic logic [15:0] sv(input int p, input int k);
      return 16'((p << 8) | k);
   endfunction

   function automatic logic [SCH*SDW-1:0] ramp(input int p);
      logic [SCH*SDW-1:0] r;
      for (int k = 0; k < SCH; k++) r[k*SDW +: SDW] = sv(p, k);
      return r;
   endfunction

   task automatic check_small(input int w);
      int f;
      int c;
      int b;
      logic [63:0] e;
      f = w / 2;
      c = w % 2;
      b = f * 8 + 2 * c;
      for (int k = 0; k < SCH; k++) begin
         e = {sv(b, k), sv(b + 1, k), sv(b + 4, k), sv(b + 5, k)};
         check("s_win_ch", win_data_s[k*64 +: 64], e);
      end
      check("s_ch15_top", 64'(win_data_s[SCH*4*SDW-1 -: 16]), 64'(sv(b, 15)));
      check("s_win_col", 64'(win_col_s), 64'(c));
      check("s_frame_done", 64'(frame_done_s), 64'(c == 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ps;
      int snw;
      int sfd;
      rst_n_s     = 1'b0;
      in_valid_s  = 1'b0;
      win_ready_s = 1'b0;
      in_data_s   = '0;
      do_reset();

      // Full frame, always-ready sink.
      mode    = 1'b0;
      chk_rdy = 1'b1;
      for (int n = 0; n < 2000 && pix_idx < FRAME; n++) begin
         cycle(1'b1, 1'b1);
         if (pix_idx == BANK) check("lat_edge_n", 64'(win_valid), 64'd0);
         if (pix_idx == BANK + 1) begin
            check("lat_edge_n1", 64'(win_valid), 64'd1);
            check("first_ch0", 64'(win_data[31:0]), 64'h00011C1D);
            check("first_col", 64'(win_col), 64'd0);
         end
      end
      chk_rdy = 1'b0;
      drain();
      check("t1_windows", 64'(nwin), 64'd196);
      check("t1_frame_done", 64'(nfd), 64'd1);

      // Stalled sink: both banks fill, then release.
      do_reset();
      for (int n = 0; n < 400 && pix_idx < 2 * BANK; n++) cycle(1'b1, 1'b0);
      check("bp_pixels", 64'(pix_idx), 64'd112);
      for (int n = 0; n < 100; n++) begin
         cycle(1'b1, 1'b0);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_win_valid", 64'(win_valid), 64'd1);
         check("bp_win_col", 64'(win_col), 64'd0);
         check("bp_ch0", 64'(win_data[31:0]), 64'h00011C1D);
      end
      check("bp_pixels_held", 64'(pix_idx), 64'd112);
      for (int n = 0; n < 14; n++) begin
         cycle(1'b1, 1'b1);
         check("bp_ready_return", 64'(in_ready), 64'(nwin >= 13));
      end
      check("bp_windows", 64'(nwin), 64'd14);

      // Random gaps and backpressure over three back-to-back frames.
      do_reset();
      mode = 1'b1;
      for (int n = 0; n < 20000 && !(pix_idx >= 3 * FRAME && exp_q.size() == 0); n++)
         cycle((pix_idx < 3 * FRAME) && ($urandom_range(3) != 0), $urandom_range(1) == 1);
      check("rand_pixels", 64'(pix_idx), 64'(3 * FRAME));
      check("rand_left", 64'(exp_q.size()), 64'd0);
      check("rand_windows", 64'(nwin), 64'(3 * FRAME / 4));
      check("rand_frame_done", 64'(nfd), 64'd3);

      // Reset in the middle of the second bank with a window held.
      do_reset();
      mode = 1'b0;
      for (int n = 0; n < 400 && pix_idx < BANK + 40; n++) cycle(1'b1, 1'b0);
      check("mid_pixels", 64'(pix_idx), 64'(BANK + 40));
      check("mid_win_valid_pre", 64'(win_valid), 64'd1);
      do_reset();
      mode = 1'b1;
      for (int n = 0; n < 400 && pix_idx < BANK; n++) cycle(1'b1, 1'b1);
      drain();
      check("mid_windows", 64'(nwin), 64'd14);

      // Wide-pixel, many-channel, tiny-frame build.
      rst_n_s = 1'b0;
      @(posedge clk);
      #1;
      check("s_rst_valid", 64'(win_valid_s), 64'd0);
      check("s_rst_data_top", win_data_s[SCH*4*SDW-1 -: 64], 64'd0);
      rst_n_s = 1'b1;
      ps  = 0;
      snw = 0;
      sfd = 0;
      for (int n = 0; n < 60 && snw < 4; n++) begin
         in_valid_s  = (ps < 16);
         in_data_s   = ramp(ps);
         win_ready_s = 1'b1;
         #1;
         if (win_valid_s && win_ready_s) begin
            check_small(snw);
            snw++;
            if (frame_done_s) sfd++;
         end
         if (in_valid_s && in_ready_s) ps++;
         @(posedge clk);
         #1;
      end
      check("s_windows", 64'(snw), 64'd4);
      check("s_frame_done_cnt", 64'(sfd), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
